// File: rtl/rand_pkg.sv
// Shared types and constants for the random-value arbiter and its LFSR.
package rand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0]  SEED_DEFAULT      = 8'h0F;
  localparam int unsigned MAX_TRIES_DEFAULT = 15;

  // Feedback taps of the 8-bit left-shifting LFSR
  localparam int unsigned TAP_A = 7;
  localparam int unsigned TAP_B = 3;
  localparam int unsigned TAP_C = 2;
  localparam int unsigned TAP_D = 0;

  // Smallest all-ones value covering lim-1; lim=0 wraps to 8'hFF (full range)
  function automatic logic [7:0] smear_mask(input logic [7:0] lim);
    logic [7:0] v;
    v = lim - 8'd1;
    v = v | (v >> 1);
    v = v | (v >> 2);
    v = v | (v >> 4);
    return v;
  endfunction

endpackage

// File: rtl/rand_arbiter_lfsr8.sv
// Free-running 8-bit LFSR, held at SEED while reset is high.
module lfsr8
  import rand_pkg::*;
#(
  parameter logic [7:0] SEED = SEED_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = r_q[TAP_A] ^ r_q[TAP_B] ^ r_q[TAP_C] ^ r_q[TAP_D];

  // Shift left every cycle, feeding the tap XOR into bit 0
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= SEED;
    end else begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one LFSR among requesters, each receiving a
// value in [0, limit) via masked rejection sampling with a bounded fallback.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int                NUM_REQ   = 4,
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  SEED      = SEED_DEFAULT,
  parameter int unsigned       MAX_TRIES = MAX_TRIES_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   limit,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           rnd_out,
  output logic                       busy
);

  localparam int unsigned NR = NUM_REQ;
  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);

  state_t               r_state;
  logic [GW-1:0]        r_g;
  logic [GW-1:0]        r_last;
  logic [WIDTH-1:0]     r_lim;
  logic [WIDTH-1:0]     r_mask;
  logic [TW-1:0]        r_tries;
  logic [NUM_REQ-1:0]   r_ack;
  logic [WIDTH-1:0]     r_rnd;

  logic [WIDTH-1:0]     w_lfsr;
  logic [WIDTH-1:0]     w_lim_arr [NUM_REQ];
  logic                 w_found;
  logic [GW-1:0]        w_pick;
  logic [WIDTH-1:0]     w_s;
  logic                 w_accept;
  logic [NUM_REQ-1:0]   w_onehot;

  lfsr8 #(
    .SEED (SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (w_lfsr)
  );

  // Unpack the per-requester limit slices
  always_comb begin
    for (int unsigned i = 0; i < NR; i++) begin
      w_lim_arr[i] = limit[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin pick: first set request at or after last_grant+1, wrapping
  always_comb begin
    logic [GW-1:0] idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = GW'((32'(r_last) + 32'd1 + k) % NR);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_pick  = idx;
      end
    end
  end

  // Masked sample and acceptance test against the latched limit
  always_comb begin
    w_s      = w_lfsr & r_mask;
    w_accept = (r_lim == '0) || (w_s < r_lim);
  end

  // One-hot decode of the active grant index
  always_comb begin
    w_onehot       = '0;
    w_onehot[r_g]  = 1'b1;
  end

  // Grant FSM with registered ack/rnd_out; ack is set on entry to RESP
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_last  <= GW'(NUM_REQ - 1);
      r_lim   <= '0;
      r_mask  <= '0;
      r_tries <= '0;
      r_ack   <= '0;
      r_rnd   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_g     <= w_pick;
            r_lim   <= w_lim_arr[w_pick];
            r_mask  <= smear_mask(w_lim_arr[w_pick]);
            r_tries <= '0;
            r_state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (!req[r_g]) begin
            // Abandoned request still advances the rotation
            r_last  <= r_g;
            r_state <= ST_IDLE;
          end else if (w_accept) begin
            r_rnd   <= w_s;
            r_ack   <= w_onehot;
            r_state <= ST_RESP;
          end else if (r_tries == TW'(MAX_TRIES)) begin
            // s < 2*lim whenever rejected, so s-lim lands inside the range
            r_rnd   <= w_s - r_lim;
            r_ack   <= w_onehot;
            r_state <= ST_RESP;
          end else begin
            r_tries <= r_tries + TW'(1);
          end
        end
        ST_RESP: begin
          r_last  <= r_g;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack     = r_ack;
  assign rnd_out = r_rnd;
  assign busy    = (r_state == ST_DRAW) || (r_state == ST_RESP);

endmodule

// File: doc/rand_arbiter.md
# rand_arbiter

Shares one free-running 8-bit LFSR random source among `NUM_REQ` requesters, such as game objects or spawners, that each need a random value in their own range `[0, limit)`. A round-robin arbiter grants one requester at a time. Range reduction uses masked rejection sampling with a bounded retry count and a deterministic fallback. The result is returned with a one-cycle `ack` pulse. The block sits between the game-logic FSMs and the LFSR and replaces direct taps of the LFSR output.

## Interface
- `NUM_REQ`, 4: number of requesters (2–8).
- `WIDTH`, 8: random/limit width; fixed at 8 for the current LFSR taps.
- `SEED`, 8'h0F: LFSR reset value; must be nonzero.
- `MAX_TRIES`, 15: rejected draws allowed before the fallback is used.
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req` in `NUM_REQ`: level request; bit i is held high until `ack[i]`.
- `limit` in `NUM_REQ*WIDTH`: packed exclusive upper bound per requester; slice i is `limit[i*WIDTH +: WIDTH]`. Value 0 means full range 0–255.
- `ack` out `NUM_REQ`: one-hot, one-cycle pulse; `rnd_out` is valid that cycle.
- `rnd_out` out `WIDTH`: returned random value; holds its last value between acks.
- `busy` out 1: high while a grant is active (DRAW or RESP).

## Operation
- **LFSR:**
  - Shift left each cycle; `next = {r[6:0], r[7]^r[3]^r[2]^r[0]}`.
  - Held at `SEED` while `reset` is high, and advances on every clock edge otherwise, regardless of arbitration.
- **FSM states:** IDLE, DRAW, RESP.
- **IDLE:**
  - If `req` is nonzero, select the first set bit starting at `(last_grant+1) mod NUM_REQ`, searching upward with wrap.
  - Latch the grant index `g`, `lim = limit[g]` and `mask`.
  - Set tries = 0 and go to DRAW.
- **mask:** smallest all-ones value ≥ `lim-1` (bit-smear of `lim-1`); 8'hFF when `lim` = 0; 8'h00 when `lim` = 1.
- **DRAW, per cycle:** `s = lfsr & mask`.
  - Accept if `lim` = 0 or `s < lim`: register `rnd_out = s` and go to RESP.
  - Else, if tries = `MAX_TRIES`, fall back: `rnd_out = s - lim` (always `< lim` because `s < 2*lim`), then go to RESP.
  - Else tries++ and stay in DRAW.
  - If `req[g]` drops while in DRAW, abort to IDLE with no ack. `last_grant` is still updated to `g`.
- **RESP:** `ack[g] = 1`, `last_grant = g`, next state IDLE.
- **Requester rule:** deassert `req[i]` on the edge that samples `ack[i]` = 1. The IDLE cycle after RESP therefore never regrants a satisfied request.
- **Reset values:**
  - FSM = IDLE, `ack` = 0, `rnd_out` = 0, `busy` = 0.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
  - LFSR = `SEED`.
- Reset asserted mid-transaction discards the grant; no ack is produced.
- `limit[g]` changes after the grant have no effect; the value is latched in IDLE.

## Timing
- **Latency:** `req` high in cycle 0 with the block in IDLE → DRAW in cycle 1 → `ack` and `rnd_out` in cycle 2 when the first draw is accepted.
- Each rejection adds 1 cycle. Worst case is 2 + `MAX_TRIES` = 17 cycles.
- Back-to-back service: IDLE → DRAW → RESP → IDLE, so at most one grant per 3 cycles.
- The next grant is decided in the IDLE cycle following RESP.
- `ack` and `rnd_out` are registered outputs, driven from the RESP state and data register.
- `busy` is decoded from state.
- **Fairness:** with all requests held, grants rotate 0, 1, 2, …, `NUM_REQ-1`, 0, …
- **Simultaneous events:** a new `req` arriving during DRAW or RESP waits for IDLE.

## Structure
- Package `rand_pkg` contains:
  - the state enum (IDLE, DRAW, RESP);
  - the `SEED` default;
  - the tap positions;
  - the `MAX_TRIES` default;
  - the mask-smear function.
- Sub-module `lfsr8`, with ports `clock`, `reset`, `q[7:0]`: a free-running LFSR with the taps above, synchronous active-high reset to `SEED`.
- The arbiter, FSM, mask logic and compare live in `rand_arbiter`.

## Test plan
- **First draw, full range:** release reset (LFSR = 0x0F in cycle 0); `req[0]` = 1 with `limit[0]` = 0 in cycle 0 → cycle 1 samples 0x1F → `ack[0]` = 1 and `rnd_out` = 0x1F in cycle 2, `busy` = 1 in cycles 1–2.
- **Rejection:**
  - Setup: `req[1]` with `limit[1]` = 5 (mask 0x07), first sampled in cycle 1.
  - Sample sequence: 0x1F, 0x3F, 0x7F, 0xFF, 0xFE; masked 7, 7, 7, 7, 6, all rejected.
  - Assert: 1 added cycle per rejection; the first accepted value is < 5; `ack[1]` only.
- **Fallback:**
  - Setup: `MAX_TRIES` = 0, `limit` = 5, sample 0x1F, masked 7.
  - Assert: `rnd_out` = 2 in cycle 2.
- **Round-robin:**
  - `req` = 4'b1111 held, each requester dropping its bit after its ack → ack order 0, 1, 2, 3, every 3 cycles.
  - Re-raise all bits → the grant starts again at 0.
- **Edge limits:** `limit` = 1 → `rnd_out` = 0 every time, with 2-cycle latency.
- **Abort and reset mid-operation:**
  - Abort: drop `req[g]` during DRAW (force rejects with `limit` = 5) → no ack, return to IDLE.
  - Reset: assert `reset` in DRAW → next cycle in IDLE, `ack` = 0, `rnd_out` = 0, LFSR = 0x0F.
